// File: rtl/apu_pkg.sv
// Shared types, instruction field positions and saturation helper for the APU core.
// Optional feature macro: APU_SATURATE_EN (consumed by apu_alu).
package apu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_MUL   = 4'h1,
        OP_LOAD  = 4'h2,
        OP_STORE = 4'h3,
        OP_JMP   = 4'h4,
        OP_BEZ   = 4'h5,
        OP_CMP   = 4'h6,
        OP_SUB   = 4'h7,
        OP_SETI  = 4'h8,
        OP_SAR   = 4'h9,
        OP_HALT  = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM
    } state_t;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RA_MSB  = 11;
    localparam int unsigned RA_LSB  = 8;
    localparam int unsigned RB_MSB  = 7;
    localparam int unsigned RB_LSB  = 4;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/apu_alu.sv
// Combinational sample ALU: ADD/SUB/MUL (fixed point), SAR, CMP.
// APU_SATURATE_EN selects clamping instead of wrap-around for ADD, SUB and MUL.
module apu_alu
    import apu_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 4
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned PW = 2 * DATA_W;

    logic signed [PW-1:0] prod;
    logic [4:0]           sh_amt;
    logic [DATA_W-1:0]    add_r;
    logic [DATA_W-1:0]    sub_r;
    logic [DATA_W-1:0]    mul_r;

    assign prod   = PW'($signed(a)) * PW'($signed(b));
    assign sh_amt = (b[4:0] > 5'(DATA_W - 1)) ? 5'(DATA_W - 1) : b[4:0];

`ifdef APU_SATURATE_EN
    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] diff;

    assign sum   = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    assign diff  = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
    assign add_r = DATA_W'(sat_signed(64'(sum), DATA_W));
    assign sub_r = DATA_W'(sat_signed(64'(diff), DATA_W));
    // Saturation is applied to the already-shifted product.
    assign mul_r = DATA_W'(sat_signed(64'(prod >>> FRAC_BITS), DATA_W));
`else
    assign add_r = a + b;
    assign sub_r = a - b;
    assign mul_r = DATA_W'(prod >>> FRAC_BITS);
`endif

    always_comb begin
        result = a;
        case (op)
            OP_ADD:  result = add_r;
            OP_SUB:  result = sub_r;
            OP_MUL:  result = mul_r;
            OP_SAR:  result = DATA_W'($signed(a) >>> sh_amt);
            OP_CMP:  result = (b == '0) ? DATA_W'(1) : '0;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/apu_core.sv
// Multi-cycle APU core: FSM, program counter and register file around apu_alu.
// Build option APU_SATURATE_EN (see apu_alu) enables saturating arithmetic.
module apu_core
    import apu_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned PC_W          = 8,
    parameter int unsigned NUM_REGS      = 4,
    parameter int unsigned FRAC_BITS     = 4,
    parameter int unsigned PROGRAM_START = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              dataReady,
    input  logic              writeAcknowledge,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataOut,
    output logic              readEnable,
    output logic              writeEnable,
    output logic              halted
);

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [NUM_REGS];

    op_t               op;
    logic [3:0]        ra_idx;
    logic [3:0]        rb_idx;
    logic [7:0]        imm;
    logic [DATA_W-1:0] ra_val;
    logic [DATA_W-1:0] rb_val;
    logic [DATA_W-1:0] alu_res;
    logic              mem_done;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    assign op     = op_t'(ir[OP_MSB:OP_LSB]);
    assign ra_idx = ir[RA_MSB:RA_LSB];
    assign rb_idx = ir[RB_MSB:RB_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

    // Indices beyond the register file read as zero.
    always_comb begin
        ra_val = '0;
        rb_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (4'(i) == ra_idx) ra_val = regs[i];
            if (4'(i) == rb_idx) rb_val = regs[i];
        end
    end

    apu_alu #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_alu (
        .op     (op),
        .a      (ra_val),
        .b      (rb_val),
        .result (alu_res)
    );

    assign mem_done = ((op == OP_LOAD) && dataReady) || ((op == OP_STORE) && writeAcknowledge);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        address     = ADDR_W'(pc);
        dataOut     = rb_val;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_IDLE: begin
                halted = 1'b1;
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                readEnable = 1'b1;
                if (dataReady) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = ST_MEM;
                    OP_HALT:           state_next = ST_IDLE;
                    default:           state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (op == OP_STORE) begin
                    address     = ADDR_W'(ra_val);
                    writeEnable = 1'b1;
                end else begin
                    address    = ADDR_W'(rb_val);
                    readEnable = 1'b1;
                end
                if (mem_done) state_next = ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_res;
        if (state == ST_EXEC) begin
            case (op)
                OP_ADD, OP_MUL, OP_SUB, OP_SAR, OP_CMP: wr_en = 1'b1;
                OP_SETI: begin
                    wr_en   = 1'b1;
                    wr_data = DATA_W'(imm);
                end
                default: wr_en = 1'b0;
            endcase
        end else if ((state == ST_MEM) && (op == OP_LOAD) && dataReady) begin
            wr_en   = 1'b1;
            wr_data = dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                if (4'(i) == ra_idx) regs[i] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_W'(PROGRAM_START);
            ir <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (start) pc <= PC_W'(PROGRAM_START);
                ST_FETCH: if (dataReady) ir <= 16'(dataIn);
                ST_EXEC: begin
                    case (op)
                        OP_LOAD, OP_STORE, OP_HALT: pc <= pc;
                        OP_JMP:  pc <= ra_val[PC_W-1:0];
                        OP_BEZ:  pc <= (ra_val == '0) ? rb_val[PC_W-1:0] : pc + 1'b1;
                        default: pc <= pc + 1'b1;
                    endcase
                end
                ST_MEM:   if (mem_done) pc <= pc + 1'b1;
                default:  pc <= pc;
            endcase
        end
    end

endmodule

// File: tb/tb_apu_core.sv
// Directed self-checking bench for apu_core with a simple wait-state memory model.
module tb_apu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dataIn;
    logic        dataReady;
    logic        writeAcknowledge;
    logic [31:0] address;
    logic [15:0] dataOut;
    logic        readEnable;
    logic        writeEnable;
    logic        halted;

    logic [15:0] prog [256];
    logic [15:0] load_data = 16'h0000;
    int          mem_wait = 0;
    int          wr_wait = 0;
    logic        force_ready = 1'b0;
    int          cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    apu_core #(
        .DATA_W        (16),
        .ADDR_W        (32),
        .PC_W          (8),
        .NUM_REGS      (4),
        .FRAC_BITS     (4),
        .PROGRAM_START (0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .dataIn           (dataIn),
        .dataReady        (dataReady),
        .writeAcknowledge (writeAcknowledge),
        .address          (address),
        .dataOut          (dataOut),
        .readEnable       (readEnable),
        .writeEnable      (writeEnable),
        .halted           (halted)
    );

    // Program space below 0x100 answers with zero wait; data space uses mem_wait.
    always @* begin
        dataIn           = (address < 32'h100) ? prog[address[7:0]] : load_data;
        dataReady        = force_ready || (readEnable && (cnt >= ((address < 32'h100) ? 0 : mem_wait)));
        writeAcknowledge = writeEnable && (cnt >= wr_wait);
    end

    always @(posedge clk) begin
        if ((readEnable && !dataReady) || (writeEnable && !writeAcknowledge)) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_prog(output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 1;
        while (!halted && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!halted) cycles = -1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({halted, readEnable, writeEnable} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100", {halted, readEnable, writeEnable});
        end
        checks++;
        if (dut.pc !== 8'h00) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=00", dut.pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.regs[i] !== 16'h0000) begin
                failures++;
                $display("FAIL reset_r%0d got=%h exp=0000", i, dut.regs[i]);
            end
        end
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({halted, readEnable, dut.pc} !== {2'b10, 8'h00}) begin
            failures++;
            $display("FAIL idle_ready got=%b exp=%b", {halted, readEnable, dut.pc}, {2'b10, 8'h00});
        end
        force_ready = 1'b0;
    endtask

    task automatic test_add();
        int cyc;
        clear_prog();
        prog[0] = 16'h8105;
        prog[1] = 16'h8207;
        prog[2] = 16'h0120;
        prog[3] = 16'hF000;
        run_prog(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL add_cycles got=%0d exp=9", cyc);
        end
        checks++;
        if (dut.regs[1] !== 16'd12) begin
            failures++;
            $display("FAIL add_r1 got=%h exp=000c", dut.regs[1]);
        end
        checks++;
        if (dut.regs[2] !== 16'd7) begin
            failures++;
            $display("FAIL add_r2 got=%h exp=0007", dut.regs[2]);
        end
        checks++;
        if ({halted, dut.pc} !== {1'b1, 8'h03}) begin
            failures++;
            $display("FAIL add_halt_pc got=%h exp=103", {halted, dut.pc});
        end
    endtask

    task automatic test_mul();
        int cyc;
        clear_prog();
        prog[0] = 16'h8130;
        prog[1] = 16'h8218;
        prog[2] = 16'h1120;
        prog[3] = 16'hF000;
        run_prog(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL mul_cycles got=%0d exp=9", cyc);
        end
        checks++;
        if (dut.regs[1] !== 16'h0048) begin
            failures++;
            $display("FAIL mul_r1 got=%h exp=0048", dut.regs[1]);
        end
    endtask

    task automatic test_mul_overflow();
        int cyc;
        logic [15:0] exp_r1;
`ifdef APU_SATURATE_EN
        exp_r1 = 16'h7FFF;
`else
        exp_r1 = 16'hFFE0;
`endif
        clear_prog();
        prog[0] = 16'h8280;
        prog[1] = 16'h0220;
        prog[2] = 16'h2120;
        prog[3] = 16'h8220;
        prog[4] = 16'h1120;
        prog[5] = 16'hF000;
        mem_wait = 0;
        load_data = 16'h7FF0;
        run_prog(cyc);
        checks++;
        if (cyc !== 14) begin
            failures++;
            $display("FAIL mulov_cycles got=%0d exp=14", cyc);
        end
        checks++;
        if (dut.regs[1] !== exp_r1) begin
            failures++;
            $display("FAIL mulov_r1 got=%h exp=%h", dut.regs[1], exp_r1);
        end
    endtask

    task automatic test_sub_sar();
        int cyc;
        clear_prog();
        prog[0]  = 16'h8103;
        prog[1]  = 16'h8205;
        prog[2]  = 16'h7120;
        prog[3]  = 16'h8301;
        prog[4]  = 16'h9230;
        prog[5]  = 16'h8310;
        prog[6]  = 16'h9130;
        prog[7]  = 16'h6030;
        prog[8]  = 16'h6300;
        prog[9]  = 16'h8509;
        prog[10] = 16'h0250;
        prog[11] = 16'hF000;
        run_prog(cyc);
        checks++;
        if (cyc !== 25) begin
            failures++;
            $display("FAIL subsar_cycles got=%0d exp=25", cyc);
        end
        checks++;
        if ({dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]} !== {16'h0000, 16'hFFFF, 16'h0002, 16'h0001}) begin
            failures++;
            $display("FAIL subsar_regs got=%h %h %h %h exp=0000 ffff 0002 0001",
                     dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]);
        end
    endtask

    task automatic test_load_wait();
        int n;
        clear_prog();
        prog[0] = 16'h8280;
        prog[1] = 16'h0220;
        prog[2] = 16'h2320;
        prog[3] = 16'hF000;
        mem_wait = 5;
        load_data = 16'hBEEF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(readEnable && address == 32'h100) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL load_req got=timeout exp=request");
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({readEnable, writeEnable, dataReady, address} !== {3'b100, 32'h100}) begin
                failures++;
                $display("FAIL load_hold%0d got=%b/%h exp=100/00000100", k,
                         {readEnable, writeEnable, dataReady}, address);
            end
            @(negedge clk);
        end
        checks++;
        if ({dataReady, dut.pc} !== {1'b1, 8'h02}) begin
            failures++;
            $display("FAIL load_ready got=%h exp=102", {dataReady, dut.pc});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({dut.regs[3], dut.pc} !== {16'hBEEF, 8'h03}) begin
            failures++;
            $display("FAIL load_result got=%h exp=beef03", {dut.regs[3], dut.pc});
        end
        n = 0;
        while (!halted && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL load_halt got=%b exp=1", halted);
        end
        mem_wait = 0;
    endtask

    task automatic test_store_reset();
        int n;
        int cyc;
        clear_prog();
        prog[0] = 16'h8280;
        prog[1] = 16'h0220;
        prog[2] = 16'h8155;
        prog[3] = 16'h3210;
        prog[4] = 16'hF000;
        wr_wait = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!writeEnable && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({writeEnable, writeAcknowledge, readEnable, address, dataOut} !== {3'b100, 32'h100, 16'h0055}) begin
            failures++;
            $display("FAIL store_req got=%b/%h/%h exp=100/00000100/0055",
                     {writeEnable, writeAcknowledge, readEnable}, address, dataOut);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({writeEnable, readEnable, halted, dut.pc} !== {3'b001, 8'h00}) begin
            failures++;
            $display("FAIL store_rst got=%b/%h exp=001/00", {writeEnable, readEnable, halted}, dut.pc);
        end
        checks++;
        if ({dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]} !== 64'h0) begin
            failures++;
            $display("FAIL store_rst_regs got=%h %h %h %h exp=0",
                     dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]);
        end
        rst = 1'b0;
        wr_wait = 0;
        run_prog(cyc);
        checks++;
        if ({cyc, dut.pc, dut.regs[1]} !== {32'd12, 8'h04, 16'h0055}) begin
            failures++;
            $display("FAIL store_done got=%0d/%h/%h exp=12/04/0055", cyc, dut.pc, dut.regs[1]);
        end
    endtask

    task automatic test_branch_wrap();
        logic [7:0] exp_seq [9];
        logic [7:0] got_seq [9];
        int         idx;
        int         n;
        exp_seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h10, 8'h11, 8'hFF, 8'h00};
        clear_prog();
        prog[8'h00] = 16'h8000;
        prog[8'h01] = 16'h8210;
        prog[8'h02] = 16'h81FF;
        prog[8'h03] = 16'h4100;
        prog[8'hFF] = 16'h5020;
        prog[8'h10] = 16'h8001;
        prog[8'h11] = 16'h4100;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        n = 0;
        while (idx < 9 && n < 200) begin
            if (readEnable && dataReady && address < 32'h100) begin
                got_seq[idx] = address[7:0];
                idx++;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (idx !== 9) begin
            failures++;
            $display("FAIL branch_fetches got=%0d exp=9", idx);
        end
        for (int i = 0; i < idx; i++) begin
            checks++;
            if (got_seq[i] !== exp_seq[i]) begin
                failures++;
                $display("FAIL branch_seq%0d got=%h exp=%h", i, got_seq[i], exp_seq[i]);
            end
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_prog();
        test_reset();
        test_add();
        test_mul();
        test_mul_overflow();
        test_sub_sar();
        test_load_wait();
        test_store_reset();
        test_branch_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
